// File: rtl/bcd_stopwatch_if.sv
// bcd_stopwatch_if: control and BCD result bundle for the stopwatch.
interface bcd_stopwatch_if #(
    parameter int NUMDIGITS = 4
);
    logic                   start_i;
    logic                   stop_i;
    logic                   clear_i;
    logic                   mode_i;
    logic                   load_i;
    logic                   lap_i;
    logic [4*NUMDIGITS-1:0] load_value_i;
    logic [4*NUMDIGITS-1:0] elapsed_o;
    logic [4*NUMDIGITS-1:0] lap_value_o;
    logic                   running_o;
    logic                   tick_o;
    logic                   done_o;
    modport master (
        output start_i, stop_i, clear_i, mode_i, load_i, lap_i, load_value_i,
        input  elapsed_o, lap_value_o, running_o, tick_o, done_o
    );
    modport slave (
        input  start_i, stop_i, clear_i, mode_i, load_i, lap_i, load_value_i,
        output elapsed_o, lap_value_o, running_o, tick_o, done_o
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: prescaled BCD up/down counter with preset load, lap capture and terminal strobes.
module bcd_stopwatch #(
    parameter int CLOCKSPEED = 10000000,
    parameter int TICK_HZ    = 1000,
    parameter int NUMDIGITS  = 4,
    parameter int WRAP       = 1
) (
    input logic clk_i,
    input logic rst_ni,
    bcd_stopwatch_if.slave sw
);
    localparam int W   = 4 * NUMDIGITS;
    localparam int DIV = CLOCKSPEED / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST  = PW'(DIV - 1);
    localparam logic [W-1:0]  NINES = {NUMDIGITS{4'h9}};

    logic [W-1:0]  elapsed_q, elapsed_d, lap_q, lap_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d, tick_q, tick_d, done_q, done_d;
    logic [W-1:0]  inc_v, dec_v, clamp_v;
    logic          cy, bw, all9, tick_en, start_block;

    // Ripple carry/borrow across all digits within one cycle
    always_comb begin
        cy = 1'b1;
        bw = 1'b1;
        inc_v = '0;
        dec_v = '0;
        clamp_v = '0;
        for (int k = 0; k < NUMDIGITS; k++) begin
            inc_v[4*k+:4] = cy ? ((elapsed_q[4*k+:4] == 4'd9) ? 4'd0 : elapsed_q[4*k+:4] + 4'd1) : elapsed_q[4*k+:4];
            dec_v[4*k+:4] = bw ? ((elapsed_q[4*k+:4] == 4'd0) ? 4'd9 : elapsed_q[4*k+:4] - 4'd1) : elapsed_q[4*k+:4];
            cy = cy && (elapsed_q[4*k+:4] == 4'd9);
            bw = bw && (elapsed_q[4*k+:4] == 4'd0);
            clamp_v[4*k+:4] = (sw.load_value_i[4*k+:4] > 4'd9) ? 4'd9 : sw.load_value_i[4*k+:4];
        end
    end

    assign all9        = elapsed_q == NINES;
    assign tick_en     = running_q && (presc_q == LAST);
    assign start_block = sw.mode_i ? (elapsed_q == '0) : (WRAP == 0 && all9);

    always_comb begin
        elapsed_d = elapsed_q;
        presc_d   = presc_q;
        running_d = running_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        lap_d     = sw.lap_i ? elapsed_q : lap_q;
        if (sw.clear_i) begin
            elapsed_d = '0;
            presc_d   = '0;
            running_d = 1'b0;
        end else if (sw.load_i) begin
            elapsed_d = clamp_v;
            presc_d   = '0;
        end else begin
            if (running_q) presc_d = tick_en ? '0 : presc_q + 1'b1;
            if (sw.stop_i) running_d = 1'b0;
            else if (sw.start_i && !start_block) running_d = 1'b1;
            // Terminal handling overrides a start arriving on the same edge
            if (tick_en) begin
                tick_d = 1'b1;
                if (!sw.mode_i) begin
                    elapsed_d = (all9 && WRAP == 0) ? NINES : inc_v;
                    done_d    = all9;
                    if (all9 && WRAP == 0) running_d = 1'b0;
                end else begin
                    elapsed_d = dec_v;
                    done_d    = dec_v == '0;
                    if (dec_v == '0) running_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elapsed_q <= '0;
            lap_q     <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            elapsed_q <= elapsed_d;
            lap_q     <= lap_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign sw.elapsed_o   = elapsed_q;
    assign sw.lap_value_o = lap_q;
    assign sw.running_o   = running_q;
    assign sw.tick_o      = tick_q;
    assign sw.done_o      = done_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: drives a wrapping and a saturating instance with shared stimulus against an integer model.
module tb_bcd_stopwatch;
    localparam int N   = 2;
    localparam int W   = 4 * N;
    localparam int DIV = 10;
    localparam int MAX = 99;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 0, stop = 0, clear = 0, mode = 0, load = 0, lap = 0;
    logic [W-1:0] lv = '0;
    always #5 clk = ~clk;

    bcd_stopwatch_if #(.NUMDIGITS(N)) s0 ();
    bcd_stopwatch_if #(.NUMDIGITS(N)) s1 ();
    assign s0.start_i = start;  assign s1.start_i = start;
    assign s0.stop_i  = stop;   assign s1.stop_i  = stop;
    assign s0.clear_i = clear;  assign s1.clear_i = clear;
    assign s0.mode_i  = mode;   assign s1.mode_i  = mode;
    assign s0.load_i  = load;   assign s1.load_i  = load;
    assign s0.lap_i   = lap;    assign s1.lap_i   = lap;
    assign s0.load_value_i = lv; assign s1.load_value_i = lv;

    bcd_stopwatch #(.CLOCKSPEED(20), .TICK_HZ(2), .NUMDIGITS(N), .WRAP(1)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .sw(s0.slave));
    bcd_stopwatch #(.CLOCKSPEED(20), .TICK_HZ(2), .NUMDIGITS(N), .WRAP(0)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .sw(s1.slave));

    int errs = 0, checks = 0;
    int cnt[2], pre[2], lapv[2];
    bit run[2], tk[2], dn[2];

    function automatic logic [W-1:0] to_bcd(int v);
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[4*k+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int clamp_int(logic [W-1:0] b);
        int v = 0, m = 1, d;
        for (int k = 0; k < N; k++) begin
            d = int'(b[4*k+:4]);
            v += ((d > 9) ? 9 : d) * m;
            m *= 10;
        end
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; pre[i] = 0; lapv[i] = 0; run[i] = 0; tk[i] = 0; dn[i] = 0;
        end
    endtask

    task automatic model(int i, bit wrap);
        bit fire, nrun;
        tk[i] = 0;
        dn[i] = 0;
        if (lap) lapv[i] = cnt[i];
        if (clear) begin
            cnt[i] = 0; pre[i] = 0; run[i] = 0;
        end else if (load) begin
            cnt[i] = clamp_int(lv); pre[i] = 0;
        end else begin
            fire = run[i] && pre[i] == DIV - 1;
            if (run[i]) pre[i] = fire ? 0 : pre[i] + 1;
            nrun = run[i];
            if (stop) nrun = 0;
            else if (start && !(mode && cnt[i] == 0) && !(!mode && !wrap && cnt[i] == MAX)) nrun = 1;
            if (fire) begin
                tk[i] = 1;
                if (!mode) begin
                    if (cnt[i] == MAX) begin
                        dn[i] = 1;
                        if (wrap) cnt[i] = 0;
                        else nrun = 0;
                    end else cnt[i]++;
                end else begin
                    cnt[i] = (cnt[i] == 0) ? MAX : cnt[i] - 1;
                    if (cnt[i] == 0) begin
                        dn[i] = 1;
                        nrun = 0;
                    end
                end
            end
            run[i] = nrun;
        end
    endtask

    task automatic compare();
        chk("wrap.elapsed", s0.elapsed_o, to_bcd(cnt[0]));
        chk("wrap.lap", s0.lap_value_o, to_bcd(lapv[0]));
        chk("wrap.running", s0.running_o, run[0]);
        chk("wrap.tick", s0.tick_o, tk[0]);
        chk("wrap.done", s0.done_o, dn[0]);
        chk("sat.elapsed", s1.elapsed_o, to_bcd(cnt[1]));
        chk("sat.lap", s1.lap_value_o, to_bcd(lapv[1]));
        chk("sat.running", s1.running_o, run[1]);
        chk("sat.tick", s1.tick_o, tk[1]);
        chk("sat.done", s1.done_o, dn[1]);
    endtask

    task automatic cyc();
        if (rst_n) begin
            model(0, 1);
            model(1, 0);
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic run_n(int n);
        repeat (n) cyc();
    endtask

    task automatic idle();
        start = 0; stop = 0; clear = 0; load = 0; lap = 0;
    endtask

    task automatic do_load(logic [W-1:0] v, logic m);
        lv = v; mode = m; load = 1;
        cyc();
        load = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        cyc();
        start = 0;
    endtask

    initial begin
        model_reset();
        run_n(2);
        rst_n = 1;
        cyc();
        chk("reset.running", s0.running_o, 0);
        // first tick lands exactly DIV cycles after start
        pulse_start();
        run_n(9);
        chk("first.notick", s0.tick_o, 0);
        cyc();
        chk("first.tick", s0.tick_o, 1);
        chk("first.elapsed", s0.elapsed_o, 8'h01);
        run_n(360);
        chk("pre_reset.elapsed", s0.elapsed_o, 8'h37);
        #2 rst_n = 0;
        #1;
        chk("async.elapsed", s0.elapsed_o, 0);
        chk("async.running", s0.running_o, 0);
        chk("async.sat.elapsed", s1.elapsed_o, 0);
        model_reset();
        cyc();
        rst_n = 1;
        cyc();
        chk("post_reset.tick", s0.tick_o, 0);

        do_load(8'h97, 0);
        pulse_start();
        run_n(30);
        chk("wrap.to_zero", s0.elapsed_o, 8'h00);
        chk("wrap.done", s0.done_o, 1);
        chk("wrap.still_running", s0.running_o, 1);
        chk("sat.hold", s1.elapsed_o, 8'h99);
        chk("sat.done", s1.done_o, 1);
        chk("sat.stopped", s1.running_o, 0);
        pulse_start();
        chk("sat.start_ignored", s1.running_o, 0);

        clear = 1; cyc(); clear = 0;
        do_load(8'h03, 1);
        pulse_start();
        run_n(30);
        chk("down.zero", s0.elapsed_o, 8'h00);
        chk("down.done", s0.done_o, 1);
        chk("down.stopped", s0.running_o, 0);
        run_n(20);
        pulse_start();
        chk("down.start_ignored", s0.running_o, 0);

        do_load(8'hA5, 0);
        chk("clamp", s0.elapsed_o, 8'h95);
        do_load(8'h19, 0);
        pulse_start();
        run_n(10);
        chk("carry_up", s0.elapsed_o, 8'h20);
        stop = 1; cyc(); stop = 0;
        do_load(8'h10, 1);
        pulse_start();
        run_n(10);
        chk("borrow_down", s0.elapsed_o, 8'h09);
        stop = 1; cyc(); stop = 0;

        clear = 1; start = 1; load = 1; lv = 8'h55;
        cyc();
        idle();
        chk("multi.elapsed", s0.elapsed_o, 8'h00);
        chk("multi.running", s0.running_o, 0);

        do_load(8'h41, 0);
        pulse_start();
        run_n(9);
        lap = 1; cyc(); lap = 0;
        chk("lap.value", s0.lap_value_o, 8'h41);
        chk("lap.elapsed", s0.elapsed_o, 8'h42);
        // pause mid-prescale; the tick resumes from the held prescaler
        run_n(4);
        stop = 1; run_n(3); stop = 0;
        pulse_start();
        run_n(4);
        chk("resume.notick", s0.tick_o, 0);
        cyc();
        chk("resume.tick", s0.tick_o, 1);
        chk("resume.elapsed", s0.elapsed_o, 8'h43);

        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 99) < 10);
            stop  = ($urandom_range(0, 99) < 3);
            clear = ($urandom_range(0, 199) < 1);
            load  = ($urandom_range(0, 99) < 2);
            lap   = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 2) mode = ~mode;
            lv = W'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
